// File: rtl/dimc_tilewrap_ctrl_if.sv
// Command port bundle between the host/CSR side and the DIMC tile-wrapper
// control sequencer.
//
// Handshake: a job transfers on a rising clock edge where cmd_valid and
// cmd_ready are both high. cmd_ready is high only while the sequencer is
// idle. The cmd_* fields must be stable whenever cmd_valid is high. Once
// asserted, cmd_valid is held until the transfer. done is a one-cycle pulse
// qualified by err/err_code, which hold until the next transfer. abort is a
// level sampled every cycle and is ignored while idle.
interface dimc_tilewrap_ctrl_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [7:0] cmd_feat_count;
   logic       cmd_psout_mode;
   logic       cmd_compute_mask;
   logic [3:0] cmd_rcsn;
   logic [3:0] cmd_disable;
   logic       abort;
   logic       busy;
   logic       done;
   logic       err;
   logic [1:0] err_code;

   modport master (
      output cmd_valid, cmd_feat_count, cmd_psout_mode, cmd_compute_mask,
             cmd_rcsn, cmd_disable, abort,
      input  cmd_ready, busy, done, err, err_code
   );

   modport slave (
      input  cmd_valid, cmd_feat_count, cmd_psout_mode, cmd_compute_mask,
             cmd_rcsn, cmd_disable, abort,
      output cmd_ready, busy, done, err, err_code
   );
endinterface

// File: rtl/dimc_tilewrap_ctrl.sv
// Command-driven control sequencer for the DIMC tile wrapper.
// Per job: SOFT_RESET pulse with configuration applied, feature fill,
// compute, drain, then a done pulse with status.
// Optional watchdog: define DIMC_TILEWRAP_CTRL_TIMEOUT_EN to abort any
// FILL/COMPUTE/DRAIN state that lasts TIMEOUT_CYCLES cycles (err_code 01).
module dimc_tilewrap_ctrl #(
   parameter int unsigned SRST_CYCLES    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                 dimc_tilewrap_clk,
   input  logic                 reset,
   dimc_tilewrap_ctrl_if.slave  cmd_if,
   output logic                 SOFT_RESET,
   output logic                 feat_en,
   output logic                 tile_en,
   output logic                 psout_mode,
   output logic                 compute_mask,
   output logic                 CG_DISABLE,
   output logic                 DISABLE_STALL,
   output logic                 DISABLE_PS_STALL,
   output logic                 DISABLE_SOUT_STALL,
   output logic                 DISABLE_PSOUT_STALL,
   output logic [7:0]           valid_feat_count,
   output logic [3:0]           rcsn_rb,
   input  logic                 feat_buff_full,
   input  logic                 feat_buff_empty,
   input  logic                 psin_buff_full,
   input  logic                 psin_buff_empty,
   input  logic                 sout_buff_full,
   input  logic                 sout_buff_empty,
   input  logic                 psout_buff_full,
   input  logic                 psout_buff_empty,
   output logic [2:0]           dbg_state,
   output logic [7:0]           dbg_buff_status
);

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_SRST    = 3'd1,
      ST_FILL    = 3'd2,
      ST_COMPUTE = 3'd3,
      ST_DRAIN   = 3'd4,
      ST_ABORT   = 3'd5
   } state_t;

   localparam logic [1:0]  CODE_OK      = 2'b00;
   localparam logic [1:0]  CODE_TIMEOUT = 2'b01;
   localparam logic [1:0]  CODE_ABORT   = 2'b10;
   localparam logic [1:0]  CODE_BADCMD  = 2'b11;
   localparam logic [15:0] SRST_LAST    = 16'(SRST_CYCLES - 1);
   localparam logic [15:0] TMO_LAST     = 16'(TIMEOUT_CYCLES - 1);
`ifdef DIMC_TILEWRAP_CTRL_TIMEOUT_EN
   localparam bit          TIMEOUT_EN   = 1'b1;
`else
   localparam bit          TIMEOUT_EN   = 1'b0;
`endif

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        err_d;
   logic [1:0]  code_d;
   logic        done_d;
   logic [1:0]  abort_code_q, abort_code_d;
   logic        cfg_load;
   logic        show_cfg;
   logic        timeout;
   logic        fill_ok, compute_ok, drain_ok;

   // latched job configuration
   logic [7:0]  cfg_fc_q, cfg_fc_d;
   logic        cfg_pm_q, cfg_pm_d;
   logic        cfg_mk_q, cfg_mk_d;
   logic [3:0]  cfg_rs_q, cfg_rs_d;
   logic [3:0]  cfg_ds_q, cfg_ds_d;

   // buffer-status conditions that move the job between phases
   always_comb begin
      fill_ok    = feat_buff_full & (~cfg_pm_q | psin_buff_full);
      compute_ok = ~sout_buff_empty | (cfg_pm_q & ~psout_buff_empty);
      drain_ok   = sout_buff_empty & (~cfg_pm_q | psout_buff_empty);
      timeout    = TIMEOUT_EN & (cnt_q == TMO_LAST);
   end

   // next-state, completion status and configuration capture
   always_comb begin
      state_d      = state_q;
      done_d       = 1'b0;
      err_d        = cmd_if.err;
      code_d       = cmd_if.err_code;
      abort_code_d = abort_code_q;
      cfg_load     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (cmd_if.cmd_valid) begin
               cfg_load = 1'b1;
               err_d    = 1'b0;
               code_d   = CODE_OK;
               if (cmd_if.cmd_feat_count == 8'd0) begin
                  done_d = 1'b1;
                  err_d  = 1'b1;
                  code_d = CODE_BADCMD;
               end else begin
                  state_d = ST_SRST;
               end
            end
         end
         ST_SRST: begin
            if (cmd_if.abort) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_ABORT;
            end else if (cnt_q == SRST_LAST) begin
               state_d = ST_FILL;
            end
         end
         ST_FILL: begin
            if (cmd_if.abort) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_ABORT;
            end else if (fill_ok) begin
               state_d = ST_COMPUTE;
            end else if (timeout) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_TIMEOUT;
            end
         end
         ST_COMPUTE: begin
            if (cmd_if.abort) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_ABORT;
            end else if (compute_ok) begin
               state_d = ST_DRAIN;
            end else if (timeout) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_TIMEOUT;
            end
         end
         ST_DRAIN: begin
            if (cmd_if.abort) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_ABORT;
            end else if (drain_ok) begin
               state_d = ST_IDLE;
               done_d  = 1'b1;
               err_d   = 1'b0;
               code_d  = CODE_OK;
            end else if (timeout) begin
               state_d      = ST_ABORT;
               abort_code_d = CODE_TIMEOUT;
            end
         end
         ST_ABORT: begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = abort_code_q;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // configuration next values and the per-state saturating cycle counter
   always_comb begin
      cfg_fc_d = cfg_load ? cmd_if.cmd_feat_count   : cfg_fc_q;
      cfg_pm_d = cfg_load ? cmd_if.cmd_psout_mode   : cfg_pm_q;
      cfg_mk_d = cfg_load ? cmd_if.cmd_compute_mask : cfg_mk_q;
      cfg_rs_d = cfg_load ? cmd_if.cmd_rcsn         : cfg_rs_q;
      cfg_ds_d = cfg_load ? cmd_if.cmd_disable      : cfg_ds_q;
      // configuration is visible while a job runs and in its done cycle
      show_cfg = (state_d != ST_IDLE) | (state_q != ST_IDLE);
      if (state_d != state_q)
         cnt_d = 16'd0;
      else if (cnt_q == 16'hFFFF)
         cnt_d = cnt_q;
      else
         cnt_d = cnt_q + 16'd1;
   end

   // state, configuration and registered outputs
   always_ff @(posedge dimc_tilewrap_clk) begin
      if (reset) begin
         state_q             <= ST_IDLE;
         cnt_q               <= 16'd0;
         abort_code_q        <= CODE_OK;
         cfg_fc_q            <= 8'd0;
         cfg_pm_q            <= 1'b0;
         cfg_mk_q            <= 1'b0;
         cfg_rs_q            <= 4'd0;
         cfg_ds_q            <= 4'd0;
         cmd_if.cmd_ready    <= 1'b1;
         cmd_if.busy         <= 1'b0;
         cmd_if.done         <= 1'b0;
         cmd_if.err          <= 1'b0;
         cmd_if.err_code     <= CODE_OK;
         SOFT_RESET          <= 1'b0;
         feat_en             <= 1'b0;
         tile_en             <= 1'b0;
         psout_mode          <= 1'b0;
         compute_mask        <= 1'b0;
         CG_DISABLE          <= 1'b0;
         DISABLE_STALL       <= 1'b0;
         DISABLE_PS_STALL    <= 1'b0;
         DISABLE_SOUT_STALL  <= 1'b0;
         DISABLE_PSOUT_STALL <= 1'b0;
         valid_feat_count    <= 8'd0;
         rcsn_rb             <= 4'd0;
         dbg_buff_status     <= 8'd0;
      end else begin
         state_q             <= state_d;
         cnt_q               <= cnt_d;
         abort_code_q        <= abort_code_d;
         cfg_fc_q            <= cfg_fc_d;
         cfg_pm_q            <= cfg_pm_d;
         cfg_mk_q            <= cfg_mk_d;
         cfg_rs_q            <= cfg_rs_d;
         cfg_ds_q            <= cfg_ds_d;
         cmd_if.cmd_ready    <= (state_d == ST_IDLE);
         cmd_if.busy         <= (state_d != ST_IDLE);
         cmd_if.done         <= done_d;
         cmd_if.err          <= err_d;
         cmd_if.err_code     <= code_d;
         SOFT_RESET          <= (state_d == ST_SRST) | (state_d == ST_ABORT);
         feat_en             <= (state_d == ST_FILL) | (state_d == ST_COMPUTE);
         tile_en             <= (state_d == ST_COMPUTE) | (state_d == ST_DRAIN);
         psout_mode          <= show_cfg & cfg_pm_d;
         compute_mask        <= show_cfg & cfg_mk_d;
         CG_DISABLE          <= 1'b0;
         DISABLE_STALL       <= show_cfg & cfg_ds_d[3];
         DISABLE_PS_STALL    <= show_cfg & cfg_ds_d[2];
         DISABLE_SOUT_STALL  <= show_cfg & cfg_ds_d[1];
         DISABLE_PSOUT_STALL <= show_cfg & cfg_ds_d[0];
         valid_feat_count    <= show_cfg ? cfg_fc_d : 8'd0;
         rcsn_rb             <= show_cfg ? cfg_rs_d : 4'd0;
         dbg_buff_status     <= {feat_buff_full, feat_buff_empty, psin_buff_full,
                                 psin_buff_empty, sout_buff_full, sout_buff_empty,
                                 psout_buff_full, psout_buff_empty};
      end
   end

   // current state for debug observation
   always_comb begin
      dbg_state = state_q;
   end

endmodule

// File: doc/dimc_tilewrap_ctrl.md
# dimc_tilewrap_ctrl

Command-driven control sequencer that drives the DIMC tile wrapper's control inputs and consumes its buffer-status outputs. It replaces testbench-driven control in integrated builds. For each accepted job it:
- pulses SOFT_RESET and applies the job configuration;
- enables the feature path, then the tile;
- waits for the result buffers to fill and drain, and reports done or error.

It sits between the host/CSR command port and the tile wrapper.

## Interface
- SRST_CYCLES, 2: SOFT_RESET assertion length in cycles, 1..15.
- TIMEOUT_CYCLES, 1024: per-state watchdog limit, 16..65535. Used only with the watchdog macro.
- dimc_tilewrap_clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  job request.
- cmd_ready  out  1  high only in IDLE.
- cmd_feat_count  in  8  number of valid 64-bit features for the job.
- cmd_psout_mode  in  1  job uses the PS in/out path.
- cmd_compute_mask  in  1  compute mask.
- cmd_rcsn  in  4  read-bank select.
- cmd_disable  in  4  {DISABLE_STALL, DISABLE_PS_STALL, DISABLE_SOUT_STALL, DISABLE_PSOUT_STALL}.
- abort  in  1  cancel the current job.
- SOFT_RESET, feat_en, tile_en, psout_mode, compute_mask, CG_DISABLE  out  1 each  tile controls. CG_DISABLE is tied to 0.
- DISABLE_STALL, DISABLE_PS_STALL, DISABLE_SOUT_STALL, DISABLE_PSOUT_STALL  out  1 each.
- valid_feat_count  out  8;  rcsn_rb  out  4.
- feat_buff_full, feat_buff_empty, psin_buff_full, psin_buff_empty, sout_buff_full, sout_buff_empty, psout_buff_full, psout_buff_empty  in  1 each  tile buffer status.
- busy  out  1  state is not IDLE.
- done  out  1  one-cycle pulse at job end.
- err  out  1  qualifies done.
- err_code  out  2  00 ok, 01 timeout, 10 abort, 11 bad command.

## Operation
- States: IDLE, SRST, FILL, COMPUTE, DRAIN, ABORT.
- All outputs are registered. Reset value of every output is 0, except cmd_ready, which is 1.
- **IDLE:** on cmd_valid & cmd_ready, all cmd_* fields are latched.
  - If cmd_feat_count == 0, the job is rejected: no state change, done=1, err=1, err_code=11 next cycle.
  - Otherwise go to SRST.
- **SRST:**
  - SOFT_RESET=1 for exactly SRST_CYCLES cycles.
  - Latched configuration drives valid_feat_count, psout_mode, compute_mask, rcsn_rb and DISABLE_* from the first SRST cycle until the cycle after done.
  - Then go to FILL.
- **FILL:**
  - feat_en=1.
  - Advance when feat_buff_full=1 and, if psout_mode, psin_buff_full=1. Both conditions must hold in the same cycle.
- **COMPUTE:**
  - feat_en=1, tile_en=1.
  - Advance when sout_buff_empty=0, or when psout_mode and psout_buff_empty=0.
- **DRAIN:**
  - tile_en=1, feat_en=0.
  - Finish when sout_buff_empty=1 and, if psout_mode, psout_buff_empty=1.
  - On finish: go to IDLE, done=1, err_code=00.
- **abort** in SRST/FILL/COMPUTE/DRAIN → ABORT:
  - feat_en=0, tile_en=0, SOFT_RESET=1 for one cycle.
  - Then IDLE with done=1, err=1, err_code=10.
  - abort in IDLE is ignored.
- err and err_code hold until the next accepted command.
- Per-state cycle counter is 16 bits. It clears on every state entry and saturates at 0xFFFF.

## Timing
- Command accepted at edge T:
  - cmd_ready=0 and SOFT_RESET=1 at T+1.
  - SOFT_RESET=0 at T+1+SRST_CYCLES; feat_en=1 in that same cycle.
- Status inputs are sampled at an edge; the resulting transition and its outputs take effect the following cycle. Minimum FILL→COMPUTE latency is 1 cycle after the full flag is seen.
- done is asserted in the same cycle that state returns to IDLE and cmd_ready=1. A new command can be accepted that cycle.
- Abort and a normal completion condition in the same cycle: abort wins.
- Abort and a timeout in the same cycle: abort wins.
- reset at any time forces IDLE and the reset values at the next edge. No done pulse is generated.
- Flags already satisfied on state entry (e.g. buffers already full): the transition happens after 1 cycle in that state. No state is skipped.

## Configuration
- DIMC_TILEWRAP_CTRL_TIMEOUT_EN defined:
  - In FILL, COMPUTE or DRAIN, if the state counter reaches TIMEOUT_CYCLES, go to ABORT behaviour (SOFT_RESET pulse).
  - Termination then reports err_code=01 instead of 10.
- Macro undefined: no watchdog. States wait indefinitely; err_code 01 is never produced.

## Test plan
- Reset, then cmd feat_count=8, psout_mode=0, SRST_CYCLES=2:
  - SOFT_RESET high exactly 2 cycles, valid_feat_count=8.
  - Drive feat_buff_full at +5, sout_buff_empty=0 at +10, sout_buff_empty=1 at +20.
  - Expect single done, err=0, err_code=00.
- psout_mode=1 job with psin_buff_full delayed 7 cycles after feat_buff_full: FILL must not exit before psin_buff_full.
- cmd_feat_count=0: done and err_code=11 one cycle after accept; SOFT_RESET never asserted.
- abort in COMPUTE: next cycle tile_en=0 and SOFT_RESET=1 for 1 cycle, then done, err_code=10.
- With the macro and TIMEOUT_CYCLES=16, hold feat_buff_full=0: timeout after 16 FILL cycles gives err_code=01. Without the macro, still busy after 100 cycles.
- reset asserted mid-DRAIN: next cycle all outputs 0, cmd_ready=1, no done.
